// File: rtl/am386sx_bus_pkg.sv
// am386sx_bus_pkg: shared types, control-bit indices and limits for the 386SX bus probe.
package am386sx_bus_pkg;
  typedef enum logic {IDLE = 1'b0, T2 = 1'b1} state_e;
  localparam int MIO = 2;
  localparam int DC = 1;
  localparam int WR = 0;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int WAIT_MAX = 15;
  localparam int DROP_MAX = 255;
endpackage

// File: rtl/bus_cycle_tracker.sv
// bus_cycle_tracker: follows 386SX bus cycles from ADS_b to READY_b on CLK2 and
// publishes one record per completed cycle through a single valid/ready register.
module bus_cycle_tracker
  import am386sx_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk2x,
  input  logic                     reset,
  input  logic                     ads_b,
  input  logic                     ready_b,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic [1:0]               be_b,
  input  logic [2:0]               control,
  input  logic [7:0]               cyc_mask,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [ADDRESS_WIDTH-1:0] rec_addr,
  output logic [DATA_WIDTH-1:0]    rec_data,
  output logic [1:0]               rec_be,
  output logic [2:0]               rec_ctl,
  output logic [3:0]               rec_wait,
  output logic                     rec_timeout,
  output logic [7:0]               drop_cnt,
  output logic                     busy
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_e                   state_q, state_d;
  logic                     phase_q, phase_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]               be_q, be_d;
  logic [2:0]               ctl_q, ctl_d;
  logic [3:0]               wait_q, wait_d, wait_inc;
  logic [7:0]               tmo_q, tmo_d, tmo_inc;
  logic                     rec_valid_q, rec_valid_d;
  logic [ADDRESS_WIDTH-1:0] rec_addr_q, rec_addr_d;
  logic [DATA_WIDTH-1:0]    rec_data_q, rec_data_d;
  logic [1:0]               rec_be_q, rec_be_d;
  logic [2:0]               rec_ctl_q, rec_ctl_d;
  logic [3:0]               rec_wait_q, rec_wait_d;
  logic                     rec_timeout_q, rec_timeout_d;
  logic [7:0]               drop_q, drop_d;
  logic                     complete, timed_out, keep, load;
  always_comb begin
    state_d = state_q;
    phase_d = ~phase_q;
    addr_d = addr_q;
    be_d = be_q;
    ctl_d = ctl_q;
    wait_d = wait_q;
    tmo_d = tmo_q;
    complete = 1'b0;
    timed_out = 1'b0;
    wait_inc = (wait_q == 4'(WAIT_MAX)) ? wait_q : wait_q + 4'd1;
    tmo_inc = tmo_q + 8'd1;
    // phase_q high means this edge ends a processor clock: the only time the bus is looked at
    if (phase_q && state_q == IDLE && !ads_b) begin
      state_d = T2;
      addr_d = address_i;
      be_d = be_b;
      ctl_d = control;
      wait_d = '0;
      tmo_d = '0;
    end else if (phase_q && state_q == T2 && !ready_b) begin
      complete = 1'b1;
      state_d = IDLE;
    end else if (phase_q && state_q == T2) begin
      wait_d = wait_inc;
      tmo_d = tmo_inc;
      complete = (tmo_inc == TMO);
      timed_out = complete;
      state_d = complete ? IDLE : T2;
    end
    keep = cyc_mask[{ctl_q[MIO], ctl_q[DC], ctl_q[WR]}];
    load = complete && keep && (!rec_valid_q || rec_ready);
    rec_valid_d = load || (rec_valid_q && !rec_ready);
    rec_addr_d = load ? addr_q : rec_addr_q;
    rec_data_d = load ? (timed_out ? '0 : data_i) : rec_data_q;
    rec_be_d = load ? be_q : rec_be_q;
    rec_ctl_d = load ? ctl_q : rec_ctl_q;
    rec_wait_d = load ? (timed_out ? wait_inc : wait_q) : rec_wait_q;
    rec_timeout_d = load ? timed_out : rec_timeout_q;
    drop_d = (complete && keep && !load && drop_q != 8'(DROP_MAX)) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk2x or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      ctl_q <= '0;
      wait_q <= '0;
      tmo_q <= '0;
      rec_valid_q <= 1'b0;
      rec_addr_q <= '0;
      rec_data_q <= '0;
      rec_be_q <= '0;
      rec_ctl_q <= '0;
      rec_wait_q <= '0;
      rec_timeout_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q <= addr_d;
      be_q <= be_d;
      ctl_q <= ctl_d;
      wait_q <= wait_d;
      tmo_q <= tmo_d;
      rec_valid_q <= rec_valid_d;
      rec_addr_q <= rec_addr_d;
      rec_data_q <= rec_data_d;
      rec_be_q <= rec_be_d;
      rec_ctl_q <= rec_ctl_d;
      rec_wait_q <= rec_wait_d;
      rec_timeout_q <= rec_timeout_d;
      drop_q <= drop_d;
    end
  end
  assign rec_valid = rec_valid_q;
  assign rec_addr = rec_addr_q;
  assign rec_data = rec_data_q;
  assign rec_be = rec_be_q;
  assign rec_ctl = rec_ctl_q;
  assign rec_wait = rec_wait_q;
  assign rec_timeout = rec_timeout_q;
  assign drop_cnt = drop_q;
  assign busy = (state_q == T2);
endmodule

// File: tb/tb_bus_cycle_tracker.sv
// tb_bus_cycle_tracker: transaction-driven random bench with a record/backpressure
// model checked every clk2x, plus directed cycles with literal expectations.
module tb_bus_cycle_tracker;
  localparam int TMO = 4;
  logic        clk2x = 1'b0, reset = 1'b1, ads_b = 1'b1, ready_b = 1'b1, rec_ready = 1'b0;
  logic [23:0] address_i = '0;
  logic [15:0] data_i = '0;
  logic [1:0]  be_b = '0;
  logic [2:0]  control = '0;
  logic [7:0]  cyc_mask = 8'hFF;
  logic        rec_valid, rec_timeout, busy;
  logic [23:0] rec_addr;
  logic [15:0] rec_data;
  logic [1:0]  rec_be;
  logic [2:0]  rec_ctl;
  logic [3:0]  rec_wait;
  logic [7:0]  drop_cnt;

  bus_cycle_tracker #(.ADDRESS_WIDTH(24), .DATA_WIDTH(16), .TIMEOUT(TMO)) dut (
    .clk2x(clk2x), .reset(reset), .ads_b(ads_b), .ready_b(ready_b), .address_i(address_i),
    .data_i(data_i), .be_b(be_b), .control(control), .cyc_mask(cyc_mask),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr), .rec_data(rec_data),
    .rec_be(rec_be), .rec_ctl(rec_ctl), .rec_wait(rec_wait), .rec_timeout(rec_timeout),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk2x = ~clk2x;

  typedef struct {
    int          e;
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [2:0]  c;
    logic [3:0]  w;
    logic        to;
  } rec_t;

  int   n_chk = 0, n_fail = 0, edge_n = 0, ads_edge = -1, rr_pct = 0, edrop = 0, busy_cnt = 0;
  logic ev = 1'b0, eb = 1'b0;
  rec_t er, cr;
  rec_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Completions are scheduled by the driver at a known edge; this applies the record rules there.
  always @(posedge clk2x or posedge reset) begin
    if (reset) begin
      edge_n = 0;
      ads_edge = -1;
      ev = 1'b0;
      eb = 1'b0;
      edrop = 0;
      er = '{default: '0};
      q.delete();
    end else begin
      edge_n++;
      if (edge_n == ads_edge) eb = 1'b1;
      if (q.size() > 0 && q[0].e == edge_n) begin
        cr = q.pop_front();
        eb = 1'b0;
        if (cyc_mask[cr.c] && (!ev || rec_ready)) begin
          er = cr;
          ev = 1'b1;
        end else if (cyc_mask[cr.c]) begin
          if (edrop < 255) edrop++;
        end else if (rec_ready) ev = 1'b0;
      end else if (rec_ready) ev = 1'b0;
    end
  end

  always @(negedge clk2x) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      chk("busy", busy, eb);
      chk("rec_valid", rec_valid, ev);
      chk("drop_cnt", drop_cnt, edrop);
      chk("rec_addr", rec_addr, er.a);
      chk("rec_data", rec_data, er.d);
      chk("rec_be", rec_be, er.be);
      chk("rec_ctl", rec_ctl, er.c);
      chk("rec_wait", rec_wait, er.w);
      chk("rec_timeout", rec_timeout, er.to);
    end
  end

  task automatic step();
    @(posedge clk2x);
    #1;
    rec_ready = ($urandom_range(99) < rr_pct);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Next edge becomes a processor-clock end (an even edge count since reset release).
  task automatic to_sample();
    if (edge_n % 2 == 0) step();
  endtask

  task automatic drain();
    rr_pct = 100;
    idle(2);
    chk("drained", rec_valid, 1'b0);
    rr_pct = 0;
  endtask

  // done_rr: 0/1 forces rec_ready on the completing edge, 2 leaves it random.
  task automatic run_cycle(input logic [23:0] a, input logic [2:0] c, input logic [1:0] be,
                           input logic [15:0] d, input int nw, input int done_rr);
    int   last = (nw >= TMO) ? TMO - 1 : nw;
    logic to = (nw >= TMO);
    logic [3:0] wt = to ? 4'((TMO > 15) ? 15 : TMO) : 4'((nw > 15) ? 15 : nw);
    to_sample();
    ads_b = 1'b0;
    address_i = a;
    control = c;
    be_b = be;
    ready_b = 1'($urandom);
    data_i = 16'($urandom);
    ads_edge = edge_n + 1;
    step();
    for (int i = 0; i <= last; i++) begin
      to_sample();
      ads_b = 1'($urandom);
      address_i = 24'($urandom);
      control = 3'($urandom);
      be_b = 2'($urandom);
      ready_b = (i < nw);
      data_i = (i == last && !to) ? d : 16'($urandom);
      if (i == last) begin
        q.push_back('{edge_n + 1, a, to ? 16'h0 : d, be, c, wt, to});
        if (done_rr < 2) rec_ready = done_rr[0];
      end
      step();
    end
    ads_b = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    er = '{default: '0};
    repeat (2) @(posedge clk2x);
    #1;
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_cnt, 8'd0);
    chk("rst_addr", rec_addr, 24'd0);
    reset = 1'b0;
    idle(3);
    busy_cnt = 0;
    run_cycle(24'hFFFFF0, 3'b110, 2'b00, 16'hEA5B, 0, 2);
    chk("t1_valid", rec_valid, 1'b1);
    chk("t1_addr", rec_addr, 24'hFFFFF0);
    chk("t1_data", rec_data, 16'hEA5B);
    chk("t1_ctl", rec_ctl, 3'b110);
    chk("t1_wait", rec_wait, 4'd0);
    chk("t1_timeout", rec_timeout, 1'b0);
    idle(2);
    chk("t1_busy_clk2x", busy_cnt, 2);
    drain();
    run_cycle(24'hFFFFF0, 3'b110, 2'b00, 16'h1234, 3, 2);
    chk("t2_wait", rec_wait, 4'd3);
    chk("t2_data", rec_data, 16'h1234);
    chk("t2_timeout", rec_timeout, 1'b0);
    drain();
    run_cycle(24'h000ABC, 3'b101, 2'b01, 16'hBEEF, 10, 2);
    chk("t3_timeout", rec_timeout, 1'b1);
    chk("t3_data", rec_data, 16'h0);
    chk("t3_wait", rec_wait, 4'd4);
    chk("t3_busy", busy, 1'b0);
    drain();
    run_cycle(24'h000ABD, 3'b111, 2'b10, 16'h5555, 1, 2);
    chk("t3_next_timeout", rec_timeout, 1'b0);
    chk("t3_next_wait", rec_wait, 4'd1);
    chk("t3_next_data", rec_data, 16'h5555);
    drain();
    cyc_mask = 8'h40;
    run_cycle(24'h000400, 3'b010, 2'b00, 16'h0404, 0, 2);
    idle(2);
    chk("t5_masked_valid", rec_valid, 1'b0);
    run_cycle(24'h000500, 3'b110, 2'b00, 16'h0505, 0, 2);
    chk("t5_valid", rec_valid, 1'b1);
    chk("t5_addr", rec_addr, 24'h000500);
    chk("t5_drop", drop_cnt, 8'd0);
    cyc_mask = 8'hFF;
    drain();
    run_cycle(24'h000100, 3'b110, 2'b00, 16'h0100, 0, 2);
    run_cycle(24'h000200, 3'b110, 2'b00, 16'h0200, 1, 2);
    chk("t4_hold_addr", rec_addr, 24'h000100);
    chk("t4_drop", drop_cnt, 8'd1);
    run_cycle(24'h000300, 3'b110, 2'b00, 16'h0300, 0, 1);
    chk("t4_load_addr", rec_addr, 24'h000300);
    chk("t4_load_valid", rec_valid, 1'b1);
    chk("t4_load_drop", drop_cnt, 8'd1);
    to_sample();
    ads_b = 1'b0;
    address_i = 24'hABCDEF;
    ads_edge = edge_n + 1;
    step();
    ads_b = 1'b1;
    ready_b = 1'b1;
    step();
    chk("t6_busy_pre", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_valid", rec_valid, 1'b0);
    chk("t6_drop", drop_cnt, 8'd0);
    @(posedge clk2x);
    #1 reset = 1'b0;
    run_cycle(24'h123456, 3'b001, 2'b11, 16'h0F0F, 0, 2);
    chk("t6_after_addr", rec_addr, 24'h123456);
    chk("t6_after_data", rec_data, 16'h0F0F);
    chk("t6_after_be", rec_be, 2'b11);
    rr_pct = 50;
    for (int k = 0; k < 40; k++) begin
      cyc_mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      run_cycle(24'($urandom), 3'($urandom), 2'($urandom), 16'($urandom), $urandom_range(6), 2);
      idle($urandom_range(3));
    end
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
